vga_timing_gen: RTL and testbench

- Upstream raster timing stage for the 640x480 @ 60 Hz image generators.
- Derives a pixel-rate clock enable from the 50 MHz board clock, replacing the PLL-generated 25 MHz domain.
- Produces registered hsync, vsync, display-enable, pixel coordinates and frame/line strobes.
- The pattern generator consumes these outputs on the same `clk`; colour gating uses `o_de`.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and pixel types for the VGA timing
// stage and the pattern generators that consume it.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COLOR_W = 4;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a 10-bit counter ordered active / front porch / sync /
// back porch, with region flags decoded from the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap,
    output logic       sync_on,
    output logic       active
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC - 1;

    generate
        if (TOTAL >= 1024 || TOTAL < 1) begin : g_bad_total
            $error("vga_axis_counter: axis total %0d does not fit 10 bits", TOTAL);
        end
    endgenerate

    logic at_end;

    assign at_end  = (count == 10'(TOTAL - 1));
    assign wrap    = en && at_end;
    assign sync_on = (count >= 10'(SYNC_START)) && (count <= 10'(SYNC_END));
    assign active  = (count < 10'(ACTIVE));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= at_end ? '0 : count + 10'd1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock enable from clk, registered syncs,
// display enable, coordinates and line/frame strobes.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_cnt port.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       o_pix_ce,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_line_start,
    output logic       o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1 (got %0d)", CLK_DIV);
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;
    logic             ce;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             h_sync_on;
    logic             h_active;
    logic             v_wrap_unused;
    logic             v_sync_on;
    logic             v_active;
    logic             de_next;

    assign ce      = (div_cnt == DIV_LAST);
    assign de_next = h_active && v_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= ce ? '0 : div_cnt + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .en      (ce),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .sync_on (h_sync_on),
        .active  (h_active)
    );

    // Vertical steps only on the pixel where the line wraps, so both axes
    // roll over together at the end of the frame.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .en      (h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap_unused),
        .sync_on (v_sync_on),
        .active  (v_active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            o_pix_ce      <= 1'b0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_pix_ce      <= ce;
            o_hsync       <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            o_de          <= de_next;
            o_x           <= de_next ? h_cnt : '0;
            o_y           <= de_next ? v_cnt : '0;
            o_line_start  <= ce && (h_cnt == '0);
            o_frame_start <= ce && (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts on the cycle the frame strobe is visible, so it reads N-1
    // during the Nth frame_start after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_frame_cnt <= '0;
        end else if (o_frame_start) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a shrunken raster so several
// frames and a mid-line reset fit in a short run.
module tb_vga_timing_gen;

    localparam int CD = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 15, VT = 8;
    localparam int FR = HT * VT * CD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce, hsync, vsync, de, line_start, frame_start;
    logic [9:0] x, y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(CD),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .o_pix_ce      (pix_ce),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_de          (de),
        .o_x           (x),
        .o_y           (y),
        .o_line_start  (line_start),
        .o_frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt   (frame_cnt)
`endif
    );

    typedef struct packed {
        logic        pix_ce;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
        logic [15:0] fcnt;
    } exp_t;

    typedef struct {
        exp_t e;
        bit   rst;
        int   k;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    k = 0;

    // Expected outputs at the k-th clock edge after reset release (k=0 is
    // the edge that samples reset), from elapsed clocks alone.
    function automatic exp_t model(input int kk);
        exp_t e;
        int n, ph, pix, h, v;
        if (kk == 0) begin
            e = '0;
            e.hsync = 1'b1;
            e.vsync = 1'b1;
            return e;
        end
        n   = kk - 1;
        ph  = n % CD;
        pix = n / CD;
        h   = pix % HT;
        v   = (pix / HT) % VT;
        e.pix_ce = (ph == CD - 1);
        e.de     = (h < HA) && (v < VA);
        e.x      = e.de ? 10'(h) : 10'd0;
        e.y      = e.de ? 10'(v) : 10'd0;
        e.hsync  = !((h >= HA + HF) && (h <= HA + HF + HS - 1));
        e.vsync  = !((v >= VA + VF) && (v <= VA + VF + VS - 1));
        e.ls     = e.pix_ce && (h == 0);
        e.fs     = e.pix_ce && (h == 0) && (v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fcnt   = (kk <= CD) ? 16'd0 : 16'((kk - CD - 1) / FR + 1);
`else
        e.fcnt   = 16'd0;
`endif
        return e;
    endfunction

    task automatic step(input bit r);
        item_t it;
        reset = r;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else   k = k + 1;
        it.e   = model(k);
        it.rst = r;
        it.k   = k;
        sb.push_back(it);
    endtask

    // Monitor: pops one expectation per clock and checks the DUT, plus
    // period checks on the strobes seen.
    int cyc = 0;
    int last_fs = 0, last_ls = 0, ls_cnt = 0, hs_cnt = 0;
    bit have_fs = 0, have_ls = 0;

    always @(negedge clk) begin
        item_t it;
        exp_t  a;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            cyc++;
            a.pix_ce = pix_ce;
            a.hsync  = hsync;
            a.vsync  = vsync;
            a.de     = de;
            a.x      = x;
            a.y      = y;
            a.ls     = line_start;
            a.fs     = frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
            a.fcnt   = frame_cnt;
`else
            a.fcnt   = 16'd0;
`endif
            n_checks++;
            if (a !== it.e) begin
                n_fail++;
                $display("FAIL outputs k=%0d rst=%0d got ce%b hs%b vs%b de%b x%0d y%0d ls%b fs%b fc%0d want ce%b hs%b vs%b de%b x%0d y%0d ls%b fs%b fc%0d",
                         it.k, it.rst, a.pix_ce, a.hsync, a.vsync, a.de, a.x, a.y, a.ls, a.fs, a.fcnt,
                         it.e.pix_ce, it.e.hsync, it.e.vsync, it.e.de, it.e.x, it.e.y, it.e.ls, it.e.fs, it.e.fcnt);
            end
            if (it.rst) begin
                have_fs = 0;
                have_ls = 0;
            end else begin
                if (a.fs) begin
                    if (have_fs) begin
                        n_checks++;
                        if (cyc - last_fs != FR) begin
                            n_fail++;
                            $display("FAIL frame_period got %0d want %0d", cyc - last_fs, FR);
                        end
                        n_checks++;
                        if (ls_cnt != VT) begin
                            n_fail++;
                            $display("FAIL lines_per_frame got %0d want %0d", ls_cnt, VT);
                        end
                    end
                    have_fs = 1;
                    last_fs = cyc;
                    ls_cnt  = 0;
                end
                if (a.ls) begin
                    if (have_ls) begin
                        n_checks++;
                        if (cyc - last_ls != HT * CD) begin
                            n_fail++;
                            $display("FAIL line_period got %0d want %0d", cyc - last_ls, HT * CD);
                        end
                        n_checks++;
                        if (hs_cnt != HS) begin
                            n_fail++;
                            $display("FAIL hsync_width got %0d want %0d", hs_cnt, HS);
                        end
                    end
                    have_ls = 1;
                    last_ls = cyc;
                    ls_cnt++;
                    hs_cnt  = 0;
                end
                if (a.pix_ce && !a.hsync) hs_cnt++;
            end
        end
    end

    initial begin
        repeat (3) step(1'b1);
        repeat (2 * FR + FR / 2) step(1'b0);
        // Walk to the pixel in the middle of hsync on line 2, then reset there.
        for (int i = 0; i < FR; i++) begin
            if (((k / CD) % (HT * VT)) == 2 * HT + HA + HF + 1) break;
            step(1'b0);
        end
        step(1'b1);
        repeat (2 * FR + 20) step(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
